// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
//   Arbitrates a single-ported shared memory between the instruction-fetch
//   port and the data-memory port of a MIPS pipeline. Data accesses win by
//   default; a waiting fetch is guaranteed a grant after STARVE_MAX
//   consecutive data grants. A transaction that sees no mem_ready for
//   WAIT_MAX busy cycles is aborted, acknowledged with zero data, and
//   raises a sticky err flag.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   if_req/if_addr           fetch request (held until if_ack) and address
//   if_rdata/if_ack          fetch read data, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata                 data request, write enable, address, write data
//   dm_rdata/dm_ack          data read data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                shared-memory request and latched access info
//   mem_rdata/mem_ready      shared-memory read data and completion
//   stall_f/stall_m          pipeline stall requests (combinational)
//   err                      sticky timeout flag
// ---------------------------------------------------------------------------
module mips_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int WAIT_MAX   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_f,
    output logic        stall_m,
    output logic        err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_D = 2'd1;
    localparam logic [1:0] S_BUSY_I = 2'd2;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [2:0]  starve_cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;

    logic        busy;
    logic        req_d;
    logic        req_i;
    logic        starved;
    logic        grant_d;
    logic        grant_i;
    logic [3:0]  wait_inc;
    logic        done_ok;
    logic        done_to;

    // A port whose ack is high this cycle has just been served; masking it
    // keeps a request that is still held from being granted a second time.
    assign req_d   = dm_req & ~dm_ack;
    assign req_i   = if_req & ~if_ack;
    assign starved = req_i && (starve_cnt == 3'(STARVE_MAX));
    assign grant_d = (state == S_IDLE) && req_d && !starved;
    assign grant_i = (state == S_IDLE) && req_i && !grant_d;

    assign busy     = (state == S_BUSY_D) || (state == S_BUSY_I);
    assign wait_inc = wait_cnt + 4'd1;
    // mem_ready in the final waiting cycle still completes normally.
    assign done_ok  = busy && mem_ready;
    assign done_to  = busy && !mem_ready && (wait_inc == 4'(WAIT_MAX));

    assign mem_req   = busy;
    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    assign stall_f = if_req & ~if_ack;
    assign stall_m = dm_req & ~dm_ack;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            starve_cnt <= 3'd0;
            err        <= 1'b0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= 32'd0;
            dm_rdata   <= 32'd0;
            lat_addr   <= 32'd0;
            lat_we     <= 1'b0;
            lat_wdata  <= 32'd0;
        end else begin
            // Acks are single-cycle pulses; only a completing transaction
            // overrides these defaults below.
            if_ack <= 1'b0;
            dm_ack <= 1'b0;

            if (grant_d) begin
                state     <= S_BUSY_D;
                wait_cnt  <= 4'd0;
                lat_addr  <= dm_addr;
                lat_we    <= dm_we;
                lat_wdata <= dm_wdata;
                // Count data grants that overtake a waiting fetch.
                if (if_req && (starve_cnt != 3'(STARVE_MAX))) begin
                    starve_cnt <= starve_cnt + 3'd1;
                end
            end else if (grant_i) begin
                state      <= S_BUSY_I;
                wait_cnt   <= 4'd0;
                starve_cnt <= 3'd0;
                lat_addr   <= if_addr;
                lat_we     <= 1'b0;
                // The fetch port has no write data; drive a clean zero.
                lat_wdata  <= 32'd0;
            end else if (done_ok || done_to) begin
                state <= S_IDLE;
                if (state == S_BUSY_I) begin
                    if_ack   <= 1'b1;
                    if_rdata <= done_ok ? mem_rdata : 32'd0;
                end else begin
                    dm_ack   <= 1'b1;
                    dm_rdata <= done_ok ? mem_rdata : 32'd0;
                end
                if (done_to) begin
                    err <= 1'b1;
                end
            end else if (busy) begin
                wait_cnt <= wait_inc;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_arbiter
//   Self-checking bench for mips_mem_arbiter. A transaction-level reference
//   model (owner of the memory, cycles waited, grants since last fetch) is
//   advanced at every rising edge from the same inputs the DUT sees, and all
//   outputs are compared on the falling edge. Directed scenarios cover the
//   fetch read, simultaneous requests, starvation, timeout and reset; a
//   randomized phase follows.
// ---------------------------------------------------------------------------
module tb_mips_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int WAIT_MAX   = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_f;
    logic        stall_m;
    logic        err;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_f   (stall_f),
        .stall_m   (stall_m),
        .err       (err)
    );

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the memory and what each port has seen.
    bit          m_busy;
    bit          m_fetch_owner;
    int          m_waited;
    int          m_data_since_fetch;
    bit          m_err;
    bit          m_if_ack;
    bit          m_dm_ack;
    logic [31:0] m_if_rdata;
    logic [31:0] m_dm_rdata;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_we;

    task automatic model_edge();
        bit          want_d;
        bit          want_i;
        bit          finish;
        logic [31:0] value;
        if (!rst) begin
            m_busy = 0; m_fetch_owner = 0; m_waited = 0; m_data_since_fetch = 0;
            m_err = 0; m_if_ack = 0; m_dm_ack = 0;
            m_if_rdata = '0; m_dm_rdata = '0; m_addr = '0; m_wdata = '0; m_we = 0;
        end else if (m_busy) begin
            m_if_ack = 0;
            m_dm_ack = 0;
            finish   = 0;
            value    = '0;
            if (mem_ready) begin
                finish = 1;
                value  = mem_rdata;
            end else begin
                m_waited++;
                if (m_waited == WAIT_MAX) begin
                    finish = 1;
                    m_err  = 1;
                end
            end
            if (finish) begin
                m_busy = 0;
                if (m_fetch_owner) begin
                    m_if_ack = 1; m_if_rdata = value;
                end else begin
                    m_dm_ack = 1; m_dm_rdata = value;
                end
            end
        end else begin
            want_d   = dm_req && !m_dm_ack;
            want_i   = if_req && !m_if_ack;
            m_if_ack = 0;
            m_dm_ack = 0;
            if (want_d && !(want_i && m_data_since_fetch == STARVE_MAX)) begin
                m_busy = 1; m_fetch_owner = 0; m_waited = 0;
                m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
                if (if_req && m_data_since_fetch < STARVE_MAX) m_data_since_fetch++;
            end else if (want_i) begin
                m_busy = 1; m_fetch_owner = 1; m_waited = 0;
                m_addr = if_addr; m_we = 0; m_wdata = '0;
                m_data_since_fetch = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("mem_req",   mem_req,   m_busy);
        check("mem_addr",  mem_addr,  m_addr);
        check("mem_we",    mem_we,    m_we);
        check("mem_wdata", mem_wdata, m_wdata);
        check("if_ack",    if_ack,    m_if_ack);
        check("dm_ack",    dm_ack,    m_dm_ack);
        check("if_rdata",  if_rdata,  m_if_rdata);
        check("dm_rdata",  dm_rdata,  m_dm_rdata);
        check("err",       err,       m_err);
        check("stall_f",   stall_f,   if_req && !m_if_ack);
        check("stall_m",   stall_m,   dm_req && !m_dm_ack);
    endtask

    // One clock cycle: compare on the falling edge, advance the model on the
    // rising edge, then return just after it so the caller can drive inputs.
    task automatic step();
        @(negedge clk);
        if (armed) compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int n;
        rst = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 0;
        step();
        armed = 1;
        step();
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1;
        step();

        // Fetch read with single-cycle memory.
        if_req = 1; if_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h8C220004;
        #1 check("f_stall_c0", stall_f, 1'b1);
        step();
        check("f_mem_req_c1", mem_req, 1'b1);
        check("f_addr_c1", mem_addr, 32'h40);
        check("f_we_c1", mem_we, 1'b0);
        check("f_stall_c1", stall_f, 1'b1);
        step();
        check("f_ack_c2", if_ack, 1'b1);
        check("f_rdata_c2", if_rdata, 32'h8C220004);
        if_req = 0; mem_ready = 0;
        step();
        check("f_ack_c3", if_ack, 1'b0);

        // Simultaneous requests, three-cycle memory: data first, then fetch.
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'h5;
        if_req = 1; if_addr = 32'h44;
        step();
        check("sim_d_addr", mem_addr, 32'h100);
        check("sim_d_we", mem_we, 1'b1);
        step();
        step();
        mem_ready = 1; mem_rdata = 32'h1234;
        step();
        check("sim_dm_ack", dm_ack, 1'b1);
        check("sim_stall_f", stall_f, 1'b1);
        dm_req = 0; mem_ready = 0;
        step();
        check("sim_i_addr", mem_addr, 32'h44);
        check("sim_i_we", mem_we, 1'b0);
        mem_ready = 1; mem_rdata = 32'hABCD;
        step();
        if_req = 0; mem_ready = 0;
        step();

        // Starvation: four data grants overtake the fetch, the fifth goes to it.
        for (int r = 0; r < 5; r++) begin
            dm_req = 1; dm_we = 0; dm_addr = 32'h100 + 32'(r);
            if_req = 1; if_addr = 32'h40; mem_ready = 1; mem_rdata = 32'(r);
            step();
            check("starve_grant", mem_addr, (r < STARVE_MAX) ? 32'h100 + 32'(r) : 32'h40);
            step();
            if_req = 0; dm_req = 0; mem_ready = 0;
            step();
        end

        // Timeout: memory never answers.
        dm_req = 1; dm_we = 0; dm_addr = 32'h200; mem_ready = 0;
        step();
        n = 0;
        while (!dm_ack && n < 40) begin
            step();
            n++;
        end
        check("to_latency", 32'(n), 32'(WAIT_MAX));
        check("to_rdata", dm_rdata, 32'h0);
        check("to_err", err, 1'b1);
        dm_req = 0;
        step();

        // Traffic after a timeout must leave err set.
        for (int c = 0; c < 20; c++) begin
            if_req = 1'($urandom); dm_req = 1'($urandom); mem_ready = 1'($urandom);
            mem_rdata = $urandom; dm_addr = $urandom; if_addr = $urandom;
            step();
        end
        check("err_sticky", err, 1'b1);

        // Reset in the second busy cycle of a fetch.
        rst = 1; if_req = 0; dm_req = 0; mem_ready = 0;
        step(); step(); step(); step();
        rst = 0; step(); rst = 1;
        if_req = 1; if_addr = 32'h48;
        step();
        step();
        rst = 0;
        step();
        check("rstb_mem_req", mem_req, 1'b0);
        check("rstb_if_ack", if_ack, 1'b0);
        check("rstb_err", err, 1'b0);
        rst = 1; if_req = 0;
        step();
        check("rstb_no_ack", if_ack, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            if_req    = ($urandom_range(0, 99) < 55);
            dm_req    = ($urandom_range(0, 99) < 55);
            dm_we     = 1'($urandom);
            if_addr   = $urandom;
            dm_addr   = $urandom;
            dm_wdata  = $urandom;
            mem_ready = ($urandom_range(0, 99) < ((c % 200) < 150 ? 40 : 3));
            mem_rdata = $urandom;
            rst       = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
